// File: rtl/user_monitor_pkg.sv
// rtl/user_monitor_pkg.sv - shared widths and types for the user channel monitor
package user_monitor_pkg;

    // Channel index carried per slot on the tag stream
    localparam int CHAN_W     = 5;
    // Tag time per slot, units of 1/3 ps
    localparam int TAGTIME_W  = 64;
    // Width of a per-channel, per-word event count (covers WORD_WIDTH up to 255)
    localparam int WORD_CNT_W = 8;

    typedef logic [WORD_CNT_W-1:0] word_cnt_t;

endpackage

// File: rtl/channel_word_decode.sv
// rtl/channel_word_decode.sv - stage 1: per-channel rising-event count and last-state select for one stream word
module channel_word_decode
    import user_monitor_pkg::*;
#(
    parameter int WORD_WIDTH   = 4,
    parameter int NUM_CHANNELS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tvalid,
    input  logic [CHAN_W*WORD_WIDTH-1:0]      channel,
    input  logic [WORD_WIDTH-1:0]             rising,
    input  logic [WORD_WIDTH-1:0]             tkeep,
    output logic                              valid_q,
    output word_cnt_t [NUM_CHANNELS-1:0]      rise_cnt,
    output logic [NUM_CHANNELS-1:0]           hit,
    output logic [NUM_CHANNELS-1:0]           last_state,
    output logic                              any_hit,
    output word_cnt_t                         ign_cnt
);

    word_cnt_t [NUM_CHANNELS-1:0] rise_cnt_n;
    logic [NUM_CHANNELS-1:0]      hit_n;
    logic [NUM_CHANNELS-1:0]      last_n;
    word_cnt_t                    ign_n;
    logic [CHAN_W-1:0]            slot_ch;

    // Walk slots in ascending order so the highest accepted slot sets the channel's last state
    always_comb begin
        rise_cnt_n = '0;
        hit_n      = '0;
        last_n     = '0;
        ign_n      = '0;
        slot_ch    = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            slot_ch = channel[i*CHAN_W +: CHAN_W];
            if (tvalid && tkeep[i]) begin
                if ({1'b0, slot_ch} >= 6'(NUM_CHANNELS)) begin
                    ign_n = ign_n + word_cnt_t'(1);
                end else begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        if (slot_ch == CHAN_W'(c)) begin
                            hit_n[c]  = 1'b1;
                            last_n[c] = rising[i];
                            if (rising[i]) begin
                                rise_cnt_n[c] = rise_cnt_n[c] + word_cnt_t'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    // Stage-1 register; cleared on reset so in-flight words are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rise_cnt   <= '0;
            hit        <= '0;
            last_state <= '0;
            any_hit    <= 1'b0;
            ign_cnt    <= '0;
        end else begin
            valid_q    <= tvalid;
            rise_cnt   <= rise_cnt_n;
            hit        <= hit_n;
            last_state <= last_n;
            any_hit    <= |hit_n;
            ign_cnt    <= ign_n;
        end
    end

endmodule

// File: rtl/user_channel_monitor.sv
// rtl/user_channel_monitor.sv - per-channel gated rising-edge counters, level and activity monitor
module user_channel_monitor
    import user_monitor_pkg::*;
#(
    parameter int WORD_WIDTH   = 4,
    parameter int NUM_CHANNELS = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int GATE_CYCLES  = 31250000,
    parameter int HOLD_CYCLES  = 62500000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [TAGTIME_W*WORD_WIDTH-1:0]      s_axis_tagtime,
    input  logic [CHAN_W*WORD_WIDTH-1:0]         s_axis_channel,
    input  logic [WORD_WIDTH-1:0]                s_axis_rising_edge,
    input  logic [WORD_WIDTH-1:0]                s_axis_tkeep,
    input  logic [$clog2(NUM_CHANNELS+1)-1:0]    rd_addr,
    output logic [CNT_WIDTH-1:0]                 rd_data,
    output logic                                 gate_done,
    output logic [NUM_CHANNELS-1:0]              level,
    output logic                                 activity
);

    localparam int AW = $clog2(NUM_CHANNELS + 1);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = CNT_WIDTH + WORD_CNT_W;

    // Saturating add of a per-word count onto a counter
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input word_cnt_t b);
        logic [SW-1:0] s;
        s = {{WORD_CNT_W{1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
        if (s[SW-1:CNT_WIDTH] != '0) begin
            return '1;
        end
        return s[CNT_WIDTH-1:0];
    endfunction

    logic                         s1_valid;
    word_cnt_t [NUM_CHANNELS-1:0] s1_rise_cnt;
    logic [NUM_CHANNELS-1:0]      s1_hit;
    logic [NUM_CHANNELS-1:0]      s1_last;
    logic                         s1_any;
    word_cnt_t                    s1_ign;

    logic [CNT_WIDTH-1:0] live    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] latched [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] ign_live;
    logic [CNT_WIDTH-1:0] ign_latched;
    logic [CNT_WIDTH-1:0] rd_mux;
    logic [GW-1:0]        gate_cnt;
    logic                 gate_last;
    logic [HW-1:0]        hold_cnt;
    logic [HW-1:0]        hold_next;
    logic                 unused_tagtime;

    assign s_axis_tready  = 1'b1;
    assign unused_tagtime = ^s_axis_tagtime;
    assign gate_last      = (gate_cnt == GW'(GATE_CYCLES - 1));

    channel_word_decode #(
        .WORD_WIDTH   (WORD_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_decode (
        .clk        (clk),
        .rst        (rst),
        .tvalid     (s_axis_tvalid),
        .channel    (s_axis_channel),
        .rising     (s_axis_rising_edge),
        .tkeep      (s_axis_tkeep),
        .valid_q    (s1_valid),
        .rise_cnt   (s1_rise_cnt),
        .hit        (s1_hit),
        .last_state (s1_last),
        .any_hit    (s1_any),
        .ign_cnt    (s1_ign)
    );

    // Stage 2: fold each word into live counters; at the window's last cycle the word goes straight into the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                live[c]    <= '0;
                latched[c] <= '0;
            end
            ign_live    <= '0;
            ign_latched <= '0;
            gate_cnt    <= '0;
            gate_done   <= 1'b0;
        end else begin
            gate_done <= gate_last;
            gate_cnt  <= gate_last ? '0 : gate_cnt + GW'(1);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (gate_last) begin
                    latched[c] <= sat_add(live[c], s1_rise_cnt[c]);
                    live[c]    <= '0;
                end else begin
                    live[c]    <= sat_add(live[c], s1_rise_cnt[c]);
                end
            end
            if (gate_last) begin
                ign_latched <= sat_add(ign_live, s1_ign);
                ign_live    <= '0;
            end else begin
                ign_live    <= sat_add(ign_live, s1_ign);
            end
        end
    end

    // Stage 2: channels touched by the word take their last-slot state, others hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (s1_valid) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (s1_hit[c]) begin
                    level[c] <= s1_last[c];
                end
            end
        end
    end

    // Hold timer reloads on any monitored event and otherwise runs down to zero
    always_comb begin
        hold_next = hold_cnt;
        if (s1_valid && s1_any) begin
            hold_next = HW'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - HW'(1);
        end
    end

    // Activity tracks the timer in the same cycle it is updated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            activity <= 1'b0;
        end else begin
            hold_cnt <= hold_next;
            activity <= (hold_next != '0);
        end
    end

    // Readout select: channel snapshots, then the ignored-event snapshot, zero beyond
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_addr == AW'(c)) begin
                rd_mux = latched[c];
            end
        end
        if (rd_addr == AW'(NUM_CHANNELS)) begin
            rd_mux = ign_latched;
        end
    end

    // Registered readout, one cycle after the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_user_channel_monitor.sv
// tb/tb_user_channel_monitor.sv - self-checking bench for user_channel_monitor
module tb_user_channel_monitor;

    localparam int WW   = 4;
    localparam int NC   = 8;
    localparam int CW   = 4;
    localparam int GATE = 40;
    localparam int HOLD = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [64*WW-1:0] s_axis_tagtime = '0;
    logic [5*WW-1:0] s_axis_channel = '0;
    logic [WW-1:0]   s_axis_rising_edge = '0;
    logic [WW-1:0]   s_axis_tkeep = '0;
    logic [3:0]      rd_addr = '0;
    logic [CW-1:0]   rd_data;
    logic            gate_done;
    logic [NC-1:0]   level;
    logic            activity;

    int checks = 0;
    int errors = 0;

    user_channel_monitor #(
        .WORD_WIDTH   (WW),
        .NUM_CHANNELS (NC),
        .CNT_WIDTH    (CW),
        .GATE_CYCLES  (GATE),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tagtime     (s_axis_tagtime),
        .s_axis_channel     (s_axis_channel),
        .s_axis_rising_edge (s_axis_rising_edge),
        .s_axis_tkeep       (s_axis_tkeep),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .gate_done          (gate_done),
        .level              (level),
        .activity           (activity)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word counts two edges after it is presented
    int          m_live [NC];
    int          m_lat  [NC];
    int          m_ign_live, m_ign_lat;
    int          gate_pos, exp_hold, edge_n;
    logic [NC-1:0] exp_level;
    logic        exp_done;
    longint      exp_rd;
    logic        h_v;
    logic [WW-1:0] h_keep, h_rise;
    int          h_ch [WW];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_live[c] = 0;
                m_lat[c]  = 0;
            end
            m_ign_live = 0; m_ign_lat = 0;
            gate_pos = 0; exp_hold = 0; edge_n = 0;
            exp_level = '0; exp_done = 1'b0; exp_rd = 0;
            h_v = 1'b0; h_keep = '0; h_rise = '0;
        end else begin
            int inc [NC];
            int ign_inc;
            bit mon;
            bit term;
            exp_rd = (int'(rd_addr) < NC) ? m_lat[rd_addr] : (int'(rd_addr) == NC) ? m_ign_lat : 0;
            for (int c = 0; c < NC; c++) inc[c] = 0;
            ign_inc = 0;
            mon = 0;
            if (h_v) begin
                for (int i = 0; i < WW; i++) begin
                    if (h_keep[i]) begin
                        if (h_ch[i] >= NC) begin
                            ign_inc++;
                        end else begin
                            mon = 1;
                            exp_level[h_ch[i]] = h_rise[i];
                            if (h_rise[i]) inc[h_ch[i]]++;
                        end
                    end
                end
            end
            term = (gate_pos == GATE - 1);
            for (int c = 0; c < NC; c++) begin
                int t;
                t = m_live[c] + inc[c];
                if (t > CMAX) t = CMAX;
                if (term) begin m_lat[c] = t; m_live[c] = 0; end
                else m_live[c] = t;
            end
            begin
                int t;
                t = m_ign_live + ign_inc;
                if (t > CMAX) t = CMAX;
                if (term) begin m_ign_lat = t; m_ign_live = 0; end
                else m_ign_live = t;
            end
            exp_done = term;
            gate_pos = term ? 0 : gate_pos + 1;
            if (mon) exp_hold = HOLD;
            else if (exp_hold > 0) exp_hold--;
            edge_n++;
            h_v    = s_axis_tvalid;
            h_keep = s_axis_tkeep;
            h_rise = s_axis_rising_edge;
            for (int i = 0; i < WW; i++) h_ch[i] = int'(s_axis_channel[i*5 +: 5]);
        end
    end

    // Per-cycle comparison of every output against the model
    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("level", level, exp_level);
            check("rd_data", rd_data, exp_rd);
            check("gate_done", gate_done, exp_done);
            check("activity", activity, exp_hold != 0);
            check("tready", s_axis_tready, 1);
        end
    end

    // Cycle of first gate_done since reset release, and length of the last activity pulse
    int since = 0, first_done_at = 0, run = 0, last_run = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            since = 0; first_done_at = 0; run = 0;
        end else begin
            since++;
            if (gate_done && first_done_at == 0) first_done_at = since;
            if (activity) run++;
            else if (run != 0) begin last_run = run; run = 0; end
        end
    end

    // Present one word so that it is sampled on edge k
    task automatic drive_at(input int k, input logic v, input logic [WW-1:0] keep,
                            input int c0, input int c1, input int c2, input int c3,
                            input logic [WW-1:0] rise);
        while (edge_n < k - 1) @(negedge clk);
        check("sched", edge_n, k - 1);
        s_axis_tvalid      = v;
        s_axis_tkeep       = keep;
        s_axis_channel     = {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
        s_axis_rising_edge = rise;
        for (int j = 0; j < 8; j++) s_axis_tagtime[j*32 +: 32] = $urandom;
        @(negedge clk);
        s_axis_tvalid      = 1'b0;
        s_axis_tkeep       = '0;
        s_axis_channel     = '0;
        s_axis_rising_edge = '0;
    endtask

    task automatic wait_edge(input int k);
        while (edge_n < k) @(negedge clk);
    endtask

    task automatic read_chk(input string name, input logic [3:0] addr, input longint exp);
        rd_addr = addr;
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog edge_n %0d expected completion", edge_n);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_gate_done", gate_done, 0);
        check("rst_activity", activity, 0);
        cmp_en = 1;
        #1 rst = 1'b0;

        // Window 1 (edges 1..40)
        drive_at(1, 1'b1, 4'b1111, 2, 2, 2, 2, 4'b1101);
        check("lat1_level2", level[2], 0);
        @(negedge clk);
        check("lat2_level2", level[2], 1);
        for (int k = 5; k <= 9; k++) drive_at(k, 1'b1, 4'b1111, 0, 0, 0, 0, 4'b1111);
        drive_at(12, 1'b1, 4'b0011, 3, 3, 0, 0, 4'b0010);
        drive_at(15, 1'b1, 4'b0010, 3, 3, 0, 0, 4'b0001);
        drive_at(20, 1'b0, 4'b1111, 1, 1, 1, 1, 4'b1111);
        drive_at(30, 1'b1, 4'b0001, 20, 0, 0, 0, 4'b0001);
        @(negedge clk);
        check("ign_activity", activity, 0);
        check("ign_level", level, 8'b0000_0101);

        // Window 2 (edges 41..80)
        drive_at(42, 1'b1, 4'b0001, 1, 0, 0, 0, 4'b0001);
        check("first_done", first_done_at, GATE);
        wait_edge(55);
        check("hold_single", last_run, 10);
        drive_at(56, 1'b1, 4'b0001, 1, 0, 0, 0, 4'b0001);
        drive_at(61, 1'b1, 4'b0001, 1, 0, 0, 0, 4'b0001);
        wait_edge(73);
        check("hold_extend", last_run, 15);
        read_chk("w1_ch0_sat", 4'd0, 15);
        read_chk("w1_ch2", 4'd2, 3);
        read_chk("w1_ch3", 4'd3, 1);
        read_chk("w1_ignored", 4'd8, 1);
        read_chk("w1_oob", 4'd9, 0);
        drive_at(79, 1'b1, 4'b0001, 5, 0, 0, 0, 4'b0001);
        drive_at(80, 1'b1, 4'b0001, 5, 0, 0, 0, 4'b0001);
        check("w2_done", gate_done, 1);
        read_chk("w2_ch5", 4'd5, 1);
        read_chk("w2_ch1", 4'd1, 3);

        // Window 3 (edges 81..120)
        wait_edge(120);
        read_chk("w3_ch1", 4'd1, 0);
        read_chk("w3_oob15", 4'd15, 0);
        read_chk("w3_ch5", 4'd5, 1);

        // Reset in the middle of window 4 with a word in flight
        drive_at(124, 1'b1, 4'b0001, 6, 0, 0, 0, 4'b0000);
        drive_at(126, 1'b1, 4'b0001, 4, 0, 0, 0, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("arst_level", level, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_gate_done", gate_done, 0);
        check("arst_activity", activity, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_edge(41);
        check("rel_first_done", first_done_at, GATE);
        read_chk("rel_ch4", 4'd4, 0);
        read_chk("rel_ch5", 4'd5, 0);
        check("rel_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
